// File: rtl/param_seq_multiplier.sv
// param_seq_multiplier: WIDTH-bit signed/unsigned shift-add multiplier, product in {A,B} with sign/carry X.
// Define ADD_SHIFT_MERGE_EN to fold the add and shift steps into one CALC cycle.
module param_seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             SignedMode,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);
`ifdef ADD_SHIFT_MERGE_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, add_a;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic x_q, x_d, sgn_q, sgn_d, busy_q, busy_d, done_q, done_d, last, add_x;
  logic [WIDTH:0] ext_a, ext_s, sum;
  assign last  = cnt_q == CNT_W'(WIDTH - 1);
  assign ext_a = {sgn_q & a_q[WIDTH-1], a_q};
  assign ext_s = {sgn_q & S[WIDTH-1], S};
  // Signed operands weigh the multiplier MSB negatively, so the final step subtracts.
  assign sum   = (sgn_q && last) ? ext_a - ext_s : ext_a + ext_s;
  assign {add_x, add_a} = b_q[0] ? sum : {x_q, a_q};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    case (state_q)
      IDLE: begin
        if (Run) begin
`ifdef ADD_SHIFT_MERGE_EN
          state_d = CALC;
`else
          state_d = ADD;
`endif
          a_d     = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          sgn_d   = SignedMode;
        end else if (ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = S;
        end
      end
`ifdef ADD_SHIFT_MERGE_EN
      CALC: begin
        a_d     = {add_x, add_a[WIDTH-1:1]};
        b_d     = {add_a[0], b_q[WIDTH-1:1]};
        x_d     = sgn_q & add_x;
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? DONE : CALC;
      end
`else
      ADD: begin
        a_d     = add_a;
        x_d     = add_x;
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d     = {x_q, a_q[WIDTH-1:1]};
        b_d     = {a_q[0], b_q[WIDTH-1:1]};
        x_d     = sgn_q & x_q;
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? DONE : ADD;
      end
`endif
      default: state_d = Run ? DONE : IDLE;
    endcase
    busy_d = state_d != IDLE && state_d != DONE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = busy_q;
  assign Done = done_q;
endmodule

// File: tb/tb_param_seq_multiplier.sv
// tb_param_seq_multiplier: random and directed multiplies checked against an arithmetic product model.
module tb_param_seq_multiplier;
  localparam int W = 8;
`ifdef ADD_SHIFT_MERGE_EN
  localparam int LAT = W;
`else
  localparam int LAT = 2 * W;
`endif
  logic Clk = 1'b0, Reset = 1'b1, Run = 1'b0, ClearA_LoadB = 1'b0, SignedMode = 1'b0;
  logic [W-1:0] S = '0, Aval, Bval;
  logic X, Busy, Done;
  logic [W-1:0] b_m;
  int n_cmp = 0, n_err = 0;
  param_seq_multiplier #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .SignedMode(SignedMode),
    .S(S), .Aval(Aval), .Bval(Bval), .X(X), .Busy(Busy), .Done(Done)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2*W-1:0] model(input logic [W-1:0] b, input logic [W-1:0] s, input logic sgn);
    longint bi, si;
    bi = sgn ? longint'($signed(b)) : longint'(b);
    si = sgn ? longint'($signed(s)) : longint'(s);
    return (2*W)'(bi * si);
  endfunction
  task automatic load(input logic [W-1:0] s);
    S = s;
    ClearA_LoadB = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    chk("load_a", Aval, 0);
    chk("load_b", Bval, s);
    b_m = s;
  endtask
  task automatic do_run(input logic [W-1:0] s, input logic sgn, input int hold, input logic clb);
    logic [2*W-1:0] p;
    int cyc;
    p = model(b_m, s, sgn);
    S = s;
    SignedMode = sgn;
    Run = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("busy_start", Busy, 1);
    cyc = 0;
    while (!Done && cyc < 100) begin
      ClearA_LoadB = clb && cyc == 2;
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      if (!Done) chk("busy_mid", Busy, 1);
    end
    ClearA_LoadB = 1'b0;
    chk("latency", cyc, LAT);
    chk("product", {Aval, Bval}, p);
    chk("x_bit", X, sgn ? p[2*W-1] : 1'b0);
    chk("busy_done", Busy, 0);
    repeat (hold) begin
      @(posedge Clk);
      @(negedge Clk);
      chk("done_held", Done, 1);
      chk("held_product", {Aval, Bval}, p);
    end
    Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("done_drop", Done, 0);
    b_m = p[W-1:0];
  endtask
  initial begin
    b_m = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_a", Aval, 0);
    chk("rst_b", Bval, 0);
    chk("rst_x", X, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    load(8'hC5);
    do_run(8'h07, 1'b1, 0, 1'b0);
    chk("tp_signed", {X, Aval, Bval}, {1'b1, 16'hFE63});
    load(8'h04);
    do_run(8'h03, 1'b0, 0, 1'b0);
    chk("tp_unsigned", {X, Aval, Bval}, {1'b0, 16'h000C});
    do_run(8'h03, 1'b0, 0, 1'b0);
    chk("tp_repeat", {Aval, Bval}, 16'h0024);
    load(8'h07);
    do_run(8'hC5, 1'b1, 0, 1'b0);
    chk("tp_swap", {X, Aval, Bval}, {1'b1, 16'hFE63});
    load(8'hFF);
    do_run(8'hFF, 1'b1, 0, 1'b0);
    chk("tp_m1m1", {X, Aval, Bval}, {1'b0, 16'h0001});
    load(8'hFF);
    do_run(8'hFF, 1'b0, 0, 1'b0);
    chk("tp_ffff", {X, Aval, Bval}, {1'b0, 16'hFE01});
    load(8'h5A);
    do_run(8'h81, 1'b1, 5, 1'b0);
    load(8'h33);
    do_run(8'h3C, 1'b0, 0, 1'b1);
    load(8'h80);
    do_run(8'h80, 1'b1, 0, 1'b1);
    S = 8'h11;
    Run = 1'b1;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("midrst_a", Aval, 0);
    chk("midrst_b", Bval, 0);
    chk("midrst_x", X, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_done", Done, 0);
    Reset = 1'b0;
    b_m = '0;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0) load(W'($urandom));
      do_run(W'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
